// File: rtl/lsu_mem_master_if.sv
// CPU-side request/response bus and word-wide RAM bus used by lsu_mem_master.
// The LSU is the slave on the request bus and the master on the RAM bus.
interface lsu_req_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if ();
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr, mem_read, mem_write, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store unit front end for a word-wide RAM without byte enables.
// Sub-word stores are done as read-modify-write; loads are lane-selected and extended.
module lsu_mem_master #(
    parameter int ADDR_W = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);
    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, RMW_RD, RMW_MRG, WR} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic [31:0] req_addr_ext;
    logic        req_misaligned;
    logic [31:0] rd_shifted;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic [3:0]  lane_sel;

    assign req_addr_ext = 32'(req.req_addr);

    always_comb begin
        case (req.req_size)
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = req_addr_ext[0];
            2'b10:   req_misaligned = |req_addr_ext[1:0];
            default: req_misaligned = 1'b1;
        endcase
    end

    // Bring the addressed byte/halfword down to bit 0 before extending.
    assign rd_shifted = mem.mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_data = uns_q ? {24'd0, rd_shifted[7:0]}
                                       : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   load_data = uns_q ? {16'd0, rd_shifted[15:0]}
                                       : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_data = mem.mem_rdata;
        endcase
    end

    // Per byte lane: keep the RAM byte unless the store targets this lane.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign lane_sel[gi] = (size_q == 2'b00) ? (addr_q[1:0] == LANE)
                                                : (addr_q[1] == LANE[1]);
        assign merged[8*gi +: 8] = !lane_sel[gi]      ? mem.mem_rdata[8*gi +: 8]
                                 : (size_q == 2'b00) ? wdata_q[7:0]
                                                     : wdata_q[8*(gi%2) +: 8];
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    addr_d  = req_addr_ext;
                    size_d  = req.req_size;
                    uns_d   = req.req_unsigned;
                    wdata_d = req.req_wdata;
                    if (req_misaligned) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req.req_we) begin
                        state_d = RD;
                    end else if (req.req_size == 2'b10) begin
                        state_d = WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            RD:      state_d = RD_WAIT;
            RD_WAIT: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
            end
            RMW_RD:  state_d = RMW_MRG;
            RMW_MRG: begin
                state_d = WR;
                wdata_d = merged;
            end
            WR: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= 32'd0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req.req_ready  = (state_q == IDLE);
    assign req.resp_valid = resp_valid_q;
    assign req.resp_err   = resp_err_q;
    assign req.resp_rdata = resp_rdata_q;

    // RAM strobes come from the registered state alone, so they are glitch-free.
    assign mem.mem_read  = (state_q == RD) || (state_q == RMW_RD);
    assign mem.mem_write = (state_q == WR);
    assign mem.mem_addr  = (state_q == IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
    assign mem.mem_wdata = (state_q == WR) ? wdata_q : 32'd0;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed cases, random traffic against a
// word-array reference model, and an abort-by-reset during a read-modify-write.
module tb_lsu_mem_master;
    localparam int ADDR_W = 32;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          accept_cyc;
        int          nrd;
        int          nwr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   ram_load = 1'b1;
    bit   in_abort = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    int   txn_no = 0;
    exp_t sbq[$];

    logic [31:0] ram    [0:255];
    logic [31:0] shadow [0:255];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_req_if #(.ADDR_W(ADDR_W)) req_bus ();
    lsu_mem_if mem_bus ();

    lsu_mem_master #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_bus),
        .mem   (mem_bus)
    );

    // RAM: one-cycle read latency, data is zero when no read was issued.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= shadow[i];
        end else if (mem_bus.mem_write) begin
            ram[mem_bus.mem_addr[9:2]] <= mem_bus.mem_wdata;
        end
        mem_bus.mem_rdata <= mem_bus.mem_read ? ram[mem_bus.mem_addr[9:2]] : 32'd0;
    end

    // Reference model: whole-transaction behaviour on a word array.
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int          idx, sh, nb;
        logic [31:0] w, mask, val;
        idx = int'(addr[9:2]);
        sh  = 8 * int'(addr[1:0]);
        w   = shadow[idx];
        e.addr = addr; e.we = we; e.size = size;
        e.rdata = 32'd0; e.nrd = 0; e.nwr = 0; e.lat = 1; e.accept_cyc = 0;
        e.err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        if (!e.err) begin
            nb   = 1 << size;
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
            if (!we) begin
                e.nrd = 1;
                e.lat = 3;
                val   = (w >> sh) & mask;
                if (!uns && nb < 4 && val[8*nb-1]) val = val | ~mask;
                e.rdata = val;
            end else if (nb == 4) begin
                e.nwr = 1;
                e.lat = 2;
                shadow[idx] = wdata;
            end else begin
                e.nrd = 1;
                e.nwr = 1;
                e.lat = 4;
                shadow[idx] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
            end
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit fixed, input logic [31:0] fixed_rdata);
        exp_t e;
        int   n;
        n = 0;
        while (!req_bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_bus.req_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL ready_timeout: req_ready=%0d after %0d cycles, required 1", req_bus.req_ready, n);
            return;
        end
        e = model(we, size, uns, addr, wdata);
        if (fixed) e.rdata = fixed_rdata;
        e.accept_cyc = cyc + 1;
        sbq.push_back(e);
        req_bus.req_we       = we;
        req_bus.req_size     = size;
        req_bus.req_unsigned = uns;
        req_bus.req_addr     = addr;
        req_bus.req_wdata    = wdata;
        req_bus.req_valid    = 1'b1;
        @(negedge clk);
        req_bus.req_valid    = 1'b0;
        // Scramble the request fields while the LSU is busy; they must be ignored.
        req_bus.req_we       = 1'($urandom);
        req_bus.req_size     = 2'($urandom);
        req_bus.req_unsigned = 1'($urandom);
        req_bus.req_addr     = $urandom;
        req_bus.req_wdata    = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: %0d responses outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %08h required %08h", nm, got, want);
        end
    endtask

    // Monitor: bus rules every cycle, strobe accounting, response scoreboard.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (!rst_n) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else if (!in_abort) begin
            tests++;
            if ((mem_bus.mem_read && mem_bus.mem_write) || mem_bus.mem_addr[1:0] != 2'b00 ||
                (!mem_bus.mem_write && mem_bus.mem_wdata != 32'd0) ||
                (req_bus.req_ready && (mem_bus.mem_read || mem_bus.mem_write || mem_bus.mem_addr != 32'd0))) begin
                fails++;
                $display("[TB] FAIL bus_rules: rd=%0d wr=%0d addr=%08h wdata=%08h ready=%0d, required no rd&wr, aligned addr, wdata 0 unless writing, idle bus quiet",
                         mem_bus.mem_read, mem_bus.mem_write, mem_bus.mem_addr, mem_bus.mem_wdata, req_bus.req_ready);
            end
            if (mem_bus.mem_read || mem_bus.mem_write) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL stray_strobe: rd=%0d wr=%0d with nothing in flight, required 0 0", mem_bus.mem_read, mem_bus.mem_write);
                end else begin
                    e = sbq[0];
                    if (mem_bus.mem_addr !== {e.addr[31:2], 2'b00}) begin
                        fails++;
                        $display("[TB] FAIL strobe_addr: got %08h required %08h", mem_bus.mem_addr, {e.addr[31:2], 2'b00});
                    end
                end
                if (mem_bus.mem_read)  rd_cnt++;
                if (mem_bus.mem_write) wr_cnt++;
            end
            if (req_bus.resp_valid) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL stray_resp: resp_valid=1 with nothing in flight, required 0");
                end else begin
                    e   = sbq.pop_front();
                    lat = cyc - e.accept_cyc + 1;
                    txn_no++;
                    $display("[TB] txn %0d we=%0d size=%0d addr=%08h rdata=%08h err=%0d lat=%0d rd=%0d wr=%0d",
                             txn_no, e.we, e.size, e.addr, req_bus.resp_rdata, req_bus.resp_err, lat, rd_cnt, wr_cnt);
                    check32("resp_rdata", req_bus.resp_rdata, e.rdata);
                    check32("resp_err", 32'(req_bus.resp_err), 32'(e.err));
                    check32("latency", 32'(lat), 32'(e.lat));
                    check32("read_strobes", 32'(rd_cnt), 32'(e.nrd));
                    check32("write_strobes", 32'(wr_cnt), 32'(e.nwr));
                    check32("ready_in_resp_cycle", 32'(req_bus.req_ready), 32'd1);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        logic        we, uns;
        logic [1:0]  size;
        logic [31:0] addr;
        int          r;

        req_bus.req_valid = 1'b0; req_bus.req_we = 1'b0; req_bus.req_size = 2'b00;
        req_bus.req_unsigned = 1'b0; req_bus.req_addr = '0; req_bus.req_wdata = '0;
        for (int i = 0; i < 256; i++) shadow[i] = $urandom;
        shadow[0]  = 32'h0BAD_F00D;
        shadow[4]  = 32'h80F1_2233;
        shadow[8]  = 32'h1122_3344;
        shadow[16] = 32'h5566_7788;

        #1 rst_n = 1'b0;
        #2;
        check32("reset_ready", 32'(req_bus.req_ready), 32'd1);
        check32("reset_resp", {req_bus.resp_rdata[29:0], req_bus.resp_valid, req_bus.resp_err}, 32'd0);
        check32("reset_strobes", {30'd0, mem_bus.mem_read, mem_bus.mem_write}, 32'd0);
        check32("reset_mem_addr", mem_bus.mem_addr, 32'd0);
        check32("reset_mem_wdata", mem_bus.mem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        ram_load = 1'b0;
        rst_n    = 1'b1;

        // Directed cases; the first request goes in on the first edge after reset.
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 1'b1, 32'hFFFF_FF80);
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 1'b1, 32'h0000_80F1);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b1, 32'h80F1_2233);
        issue(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAB, 1'b1, 32'd0);
        drain();
        check32("byte_store_ram", ram[8], 32'h1122_AB44);
        issue(1'b1, 2'b10, 1'b0, 32'h22, 32'hDEAD_BEEF, 1'b0, 32'd0);
        issue(1'b1, 2'b11, 1'b0, 32'h00, 32'hDEAD_BEEF, 1'b0, 32'd0);
        drain();
        check32("err_store_ram20", ram[8], 32'h1122_AB44);
        check32("err_store_ram0", ram[0], 32'h0BAD_F00D);
        issue(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D, 1'b1, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 1'b1, 32'hCAFE_F00D);
        drain();

        // Random traffic, biased towards aligned accesses.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            r    = int'($urandom_range(0, 15));
            size = (r == 0) ? 2'b11 : 2'(r % 3);
            addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'b01) addr[0] = 1'b0;
                if (size == 2'b10) addr[1:0] = 2'b00;
            end
            issue(we, size, uns, addr, $urandom, 1'b0, 32'd0);
        end
        drain();

        tests++;
        begin
            int bad;
            bad = -1;
            for (int i = 0; i < 256; i++) if (ram[i] !== shadow[i] && bad < 0) bad = i;
            if (bad >= 0) begin
                fails++;
                $display("[TB] FAIL ram_final: word %0d got %08h required %08h", bad, ram[bad], shadow[bad]);
            end
        end

        // Reset during RMW_MRG of a half store must abort without writing.
        in_abort = 1'b1;
        saved = shadow[16];
        req_bus.req_we = 1'b1; req_bus.req_size = 2'b01; req_bus.req_unsigned = 1'b0;
        req_bus.req_addr = 32'h42; req_bus.req_wdata = 32'h0000_BEEF; req_bus.req_valid = 1'b1;
        @(negedge clk);
        req_bus.req_valid = 1'b0;
        check32("abort_rmw_read", 32'(mem_bus.mem_read), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check32("abort_ready", 32'(req_bus.req_ready), 32'd1);
        check32("abort_resp", {req_bus.resp_rdata[29:0], req_bus.resp_valid, req_bus.resp_err}, 32'd0);
        check32("abort_strobes", {30'd0, mem_bus.mem_read, mem_bus.mem_write}, 32'd0);
        check32("abort_mem_addr", mem_bus.mem_addr, 32'd0);
        check32("abort_mem_wdata", mem_bus.mem_wdata, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check32("abort_no_write", 32'(mem_bus.mem_write), 32'd0);
        end
        rst_n    = 1'b1;
        in_abort = 1'b0;
        repeat (6) @(negedge clk);
        check32("abort_ram_unchanged", ram[16], saved);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
